// File: rtl/vedic_pkg.sv
// Shared definitions for the signed Vedic multiplier final stage:
// default half-operand width, FSM encoding and accumulation step range.
package vedic_pkg;

    localparam int unsigned N_DEF  = 16;
    localparam int unsigned STEP_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [STEP_W-1:0] STEP_FIRST = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(3);

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell built from two half adders.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/ripple_carry_adder.sv
// W-bit ripple-carry adder chained from full adder cells; cin feeds bit 0.
module ripple_carry_adder #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout = carry[W];

endmodule

// File: rtl/vedic_pp_accumulator.sv
// Final stage of the signed Vedic multiplier: sums the four partial products
// over three cycles on one shared adder, applies the sign, hands off under valid/ready.
module vedic_pp_accumulator
    import vedic_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] pp_ll,
    input  logic [2*N-1:0] pp_lh,
    input  logic [2*N-1:0] pp_hl,
    input  logic [2*N-1:0] pp_hh,
    input  logic           neg,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*N-1:0] product
);

    localparam int unsigned PW = 2 * N;
    localparam int unsigned RW = 4 * N;

    state_t              state;
    logic [STEP_W-1:0]   step;
    logic [RW-1:0]       acc;
    logic [PW-1:0]       lh_q;
    logic [PW-1:0]       hl_q;
    logic [PW-1:0]       hh_q;
    logic                neg_q;

    logic [RW-1:0]       add_a;
    logic [RW-1:0]       add_b;
    logic                add_cin;
    logic [RW-1:0]       add_sum;
    logic                add_cout;

    // Operand select for the shared adder: shifted partial product in ACC, ~acc+1 in NEG.
    always_comb begin
        add_a   = acc;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            ST_ACC: begin
                case (step)
                    STEP_FIRST:        add_b = {{N{1'b0}}, lh_q, {N{1'b0}}};
                    STEP_W'(2):        add_b = {{N{1'b0}}, hl_q, {N{1'b0}}};
                    default:           add_b = {hh_q, {PW{1'b0}}};
                endcase
            end
            ST_NEG: begin
                add_a   = ~acc;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    ripple_carry_adder #(.W(RW)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (add_cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            step      <= '0;
            acc       <= '0;
            lh_q      <= '0;
            hl_q      <= '0;
            hh_q      <= '0;
            neg_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= RW'(pp_ll);
                        lh_q     <= pp_lh;
                        hl_q     <= pp_hl;
                        hh_q     <= pp_hh;
                        neg_q    <= neg;
                        step     <= STEP_FIRST;
                        in_ready <= 1'b0;
                        state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    // Legal partial products never overflow the 4N-bit magnitude.
                    assert (!add_cout);
                    acc <= add_sum;
                    if (step == STEP_LAST) begin
                        step  <= '0;
                        state <= ST_NEG;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                ST_NEG: begin
                    if (neg_q) begin
                        acc     <= add_sum;
                        product <= add_sum;
                    end else begin
                        product <= acc;
                    end
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
